// File: rtl/vmem1_map_gen.sv
// Stage-1 virtual memory map for the paging path.
// Indexed by {vmap, mapi}; registered read with valid flag, read/write
// forwarding, and a self-timed sweep that loads INIT_VAL into every entry
// after reset or on a clear command.
module vmem1_map_gen #(
  parameter int unsigned       HI_W     = 5,
  parameter int unsigned       LO_W     = 5,
  parameter int unsigned       DATA_W   = 24,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [HI_W-1:0]        vmap,
  input  logic [LO_W-1:0]        mapi,
  input  logic [DATA_W-1:0]      vma,
  input  logic                   vm1rp,
  input  logic                   vm1wp,
  input  logic                   clear,
  output logic [HI_W+LO_W-1:0]   vmem1_adr,
  output logic [DATA_W-1:0]      vmo,
  output logic                   vmo_valid,
  output logic                   busy
);

  localparam int unsigned AW    = HI_W + LO_W;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {StClear, StIdle} state_e;

  state_e            state;
  logic [AW-1:0]     ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign vmem1_adr = {vmap, mapi};

  // Single write port: sweep owns it in StClear, the user in StIdle.
  // A clear request suppresses the write in either state.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = vmem1_adr;
    mem_wdata = vma;
    if (!reset && !clear) begin
      if (state == StClear) begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = INIT_VAL;
      end else if (vm1wp) begin
        mem_we = 1'b1;
      end
    end
  end

  // RAM array, no reset; contents are established by the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM with registered read data, valid and busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StClear;
      ptr       <= '0;
      vmo       <= '0;
      vmo_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      unique case (state)
        StClear: begin
          vmo_valid <= 1'b0;
          if (clear) begin
            ptr <= '0;
          end else if (ptr == '1) begin
            // Last entry written this edge; sweep never wraps.
            ptr   <= '0;
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        StIdle: begin
          if (clear) begin
            state     <= StClear;
            ptr       <= '0;
            busy      <= 1'b1;
            vmo_valid <= 1'b0;
          end else if (vm1rp) begin
            // Concurrent write forwards its data so the read is never stale.
            vmo       <= vm1wp ? vma : mem[vmem1_adr];
            vmo_valid <= 1'b1;
          end else begin
            vmo_valid <= 1'b0;
          end
        end
        default: begin
          state <= StClear;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/vmem1_map_gen.md
Name: vmem1_map_gen

Overview:
- Parametrised stage-1 virtual memory map for the CADR paging path. Generalises the fixed 1Kx24 level-1 map.
- Index = {vmap, mapi slice}. Index width, data width and the init pattern are parameters.
- Adds a registered read with a valid flag, same-cycle write-to-read forwarding, and a self-timed clear sweep after reset or on command.
- Sits between the map-select logic (vmap/mapi) and the stage-2 map, which consumes vmo.

Parameters:
- HI_W, 5, width of vmap (upper index bits).
- LO_W, 5, width of the mapi slice (lower index bits).
- DATA_W, 24, map entry width.
- INIT_VAL, 0, value written to every entry by the clear sweep.
- DEPTH = 2^(HI_W+LO_W), derived, not overridable.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- vmap  in  HI_W  map select, upper index.
- mapi  in  LO_W  lower index, taken from the caller's mapi field.
- vma  in  DATA_W  write data.
- vm1rp  in  1  read pulse.
- vm1wp  in  1  write pulse.
- clear  in  1  start/restart the clear sweep.
- vmem1_adr  out  HI_W+LO_W  combinational {vmap, mapi}.
- vmo  out  DATA_W  registered read data.
- vmo_valid  out  1  vmo updated by a read on the previous edge.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset:
  - Async assert: state=CLEAR, sweep ptr=0, vmo=0, vmo_valid=0, busy=1.
  - vmem1_adr is combinational and unaffected by reset.
  - RAM contents are not reset directly; the sweep initialises them.
- FSM states: CLEAR, IDLE.
- CLEAR state:
  - Each cycle: mem[ptr]<=INIT_VAL, ptr<=ptr+1.
  - On the edge that writes ptr==DEPTH-1, go to IDLE. busy falls that edge.
  - Sweep length is exactly DEPTH cycles after reset release.
  - vm1rp and vm1wp are ignored; vmo holds; vmo_valid=0.
  - clear asserted in CLEAR restarts the sweep: ptr<=0, no write of the current ptr that cycle.
- IDLE state:
  - clear=1: go to CLEAR with ptr=0, busy=1 next cycle. A vm1wp/vm1rp in the same cycle is dropped.
  - Write: vm1wp=1 gives mem[vmem1_adr]<=vma at the edge.
  - Read: vm1rp=1 and vm1wp=0 gives vmo<=mem[vmem1_adr] and vmo_valid<=1 at the next edge. Latency is 1 cycle.
  - Read and write together (vm1rp=1 and vm1wp=1): the write is performed, vmo<=vma (forwarded), vmo_valid<=1.
  - No read: vmo holds its last value; vmo_valid<=0.
  - A read one cycle after a write to the same address returns the new data. The RAM is write-first; no stale window.
- Index arithmetic:
  - vmem1_adr = {vmap, mapi}, no wrap or offset. All DEPTH entries are reachable.
  - Sweep ptr is HI_W+LO_W bits plus a terminal compare; it never wraps into a second pass.
- Reset mid-sweep or mid-read: state is forced per the Reset bullet and the sweep restarts from 0. No partial vmo update.
- Single-port RAM inference: at most one write per cycle. Sweep and user writes are mutually exclusive by state.

Test Plan:
- Reset release with defaults:
  - busy stays 1 for exactly 1024 cycles, then 0.
  - Then reading any index (vmap=5'h1F, mapi=5'h1F) returns vmo=24'h000000 with vmo_valid=1 one cycle later.
- Write then read:
  - In IDLE, write vmap=3, mapi=7, vma=24'hABCDEF (vmem1_adr=10'h067).
  - Next cycle read the same address: vmo=24'hABCDEF, vmo_valid=1. The adjacent address 10'h066 still reads 0.
- Simultaneous read and write:
  - vm1rp=vm1wp=1, address 10'h3FF, vma=24'h123456.
  - Next cycle vmo=24'h123456, vmo_valid=1. A subsequent plain read of 10'h3FF also returns 24'h123456.
- Accesses ignored during sweep:
  - Pulse clear in IDLE, then assert vm1wp (vma=24'h00FFFF) and vm1rp at cycle 10 of the sweep.
  - vmo_valid stays 0. After busy falls, that address reads 0.
- Clear restart:
  - Assert clear again at sweep cycle 500. busy remains 1 for 1024 cycles after the restart edge (1524 total).
- Reset mid-sweep:
  - Assert reset at sweep cycle 300: vmo=0, vmo_valid=0, busy=1 immediately (asynchronous).
  - After release, a full 1024-cycle sweep runs.
  - Also check a parametrised build (HI_W=4, LO_W=6, DATA_W=32, INIT_VAL=32'hFFFFFFFF): 1024-cycle sweep, reads return FFFFFFFF.
